// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID write bypass, load-use bubble insertion
// and branch-flush handling.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [RADDR-1:0] rs1_id,
  input  logic [RADDR-1:0] rs2_id,
  input  logic [RADDR-1:0] rd_id,
  input  logic [XLEN-1:0]  ReadData1,
  input  logic [XLEN-1:0]  ReadData2,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [3:0]       funct_id,
  input  logic [7:0]       ctrl_id,
  input  logic             flush,
  input  logic             wb_RegWrite,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_WriteData,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1val,
  output logic [XLEN-1:0]  ex_rs2val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RADDR-1:0] ex_rs1,
  output logic [RADDR-1:0] ex_rs2,
  output logic [RADDR-1:0] ex_rd,
  output logic [3:0]       ex_funct,
  output logic [7:0]       ex_ctrl,
  output logic             ex_valid,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write
);

  localparam int MEMREAD_BIT = 6;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            wb_live;
  logic            haz;

  // The register file writes on the same edge we capture, so forward the WB value.
  assign wb_live = wb_RegWrite && (wb_rd != '0);
  assign op1     = (wb_live && (wb_rd == rs1_id)) ? wb_WriteData : ReadData1;
  assign op2     = (wb_live && (wb_rd == rs2_id)) ? wb_WriteData : ReadData2;

  assign haz = ex_valid && ex_ctrl[MEMREAD_BIT] && (ex_rd != '0) &&
               ((ex_rd == rs1_id) || (ex_rd == rs2_id));

  assign stall       = haz && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc     <= '0;
      ex_rs1val <= '0;
      ex_rs2val <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
    end else if (flush) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
    end else if (stall) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
    end else begin
      ex_pc     <= pc_id;
      ex_rs1val <= op1;
      ex_rs2val <= op2;
      ex_imm    <= imm_id;
      ex_rs1    <= rs1_id;
      ex_rs2    <= rs2_id;
      ex_rd     <= rd_id;
      ex_funct  <= funct_id;
      ex_ctrl   <= ctrl_id;
      ex_valid  <= 1'b1;
    end
  end

endmodule
